fetch_prefetch: RTL

FETCH_PREFETCH -- requirements
Module: fetch_prefetch

---
 rtl/fetch_prefetch_pkg.sv | 13 +
 rtl/fetch_queue.sv | 71 +++++++
 rtl/fetch_prefetch.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_pkg.sv
// Shared fetch-stage definitions: the prefetch FSM state encoding and the default NOP encoding.
package fetch_prefetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SQUASH = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  localparam logic [15:0] NOP_INST_DEFAULT = 16'h0800;

endpackage

// File: rtl/fetch_queue.sv
// Instruction queue for the prefetcher: power-of-2 FIFO with push, pop, flush, full, empty and count.
module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full queue is legal only when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction prefetcher: single-outstanding fetch FSM feeding a small instruction queue.
// Define FETCH_PERF_CNT_EN to add the stall_cnt / flush_cnt performance counters.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | no request outstanding; issue when queue has room
// ST_WAIT   | request outstanding; response will be queued
// ST_SQUASH | request outstanding after a redirect; response dropped
// ST_HALTED | halt asserted, no new requests
module fetch_prefetch
  import fetch_prefetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INST   = DATA_WIDTH'(NOP_INST_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic                  mem_done,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_err,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [DATA_WIDTH-1:0] inst_pc,
  output logic [DATA_WIDTH-1:0] inc_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_addr,
  input  logic                  halt,
  output logic                  err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DEPTH+1);

  fetch_state_e    state_q, state_d;
  logic [DW-1:0]   pc_q, pc_d;
  logic [DW-1:0]   req_addr_q, req_addr_d;
  logic            err_q, err_d;
  logic [DW:0]     pc_sum;
  logic            resp_keep, pop_fire, room;
  logic            q_full, q_empty;
  logic [CW-1:0]   q_count;
  logic [2*DW-1:0] q_head;

  assign pop_fire  = inst_valid & inst_ready;
  assign resp_keep = (state_q == ST_WAIT) & mem_done & ~redirect;
  // Counting the head leaving this cycle lets a full queue re-request one cycle earlier.
  assign room      = ~q_full | pop_fire;
  assign pc_sum    = {1'b0, pc_q} + {{(DW-1){1'b0}}, 2'b10};

  fetch_queue #(
    .WIDTH (2*DW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (resp_keep),
    .push_data_i ({req_addr_q, mem_data}),
    .pop_i       (pop_fire & ~redirect),
    .flush_i     (redirect),
    .head_o      (q_head),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .count_o     (q_count)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    err_d      = err_q;

    if (resp_keep) begin
      pc_d = pc_sum[DW-1:0];
      if (mem_err || pc_sum[DW]) err_d = 1'b1;
    end
    if (redirect) pc_d = redirect_addr;

    unique case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          state_d = ST_IDLE;
        end else if (halt) begin
          state_d = ST_HALTED;
        end else if (room) begin
          state_d    = ST_WAIT;
          req_addr_d = pc_q;
        end
      end
      ST_WAIT: begin
        if (mem_done)      state_d = ST_IDLE;
        else if (redirect) state_d = ST_SQUASH;
      end
      ST_SQUASH: begin
        if (mem_done) state_d = ST_IDLE;
      end
      ST_HALTED: begin
        if (redirect || !halt) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      err_q      <= err_d;
    end
  end

  assign mem_req    = (state_q == ST_WAIT) || (state_q == ST_SQUASH);
  assign mem_addr   = mem_req ? req_addr_q : pc_q;
  assign inst_valid = (q_count != '0);
  assign inst       = q_empty ? NOP_INST : q_head[DW-1:0];
  assign inst_pc    = q_head[2*DW-1:DW];
  assign inc_pc     = inst_pc + DW'(2);
  assign err        = err_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (inst_ready && !inst_valid) stall_q <= stall_q + 32'd1;
      if (redirect)                  flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`endif

endmodule
